seg7_scan_driver: RTL and testbench

- Time-multiplexed N-digit hexadecimal seven-segment display driver for the calculator's display path.
- Generalises the single-segment, single-digit combinational decode to a full 7-segment hex decode for all digits.
- Adds a shadow register, a refresh prescaler, digit scanning, per-digit blanking and selectable output polarity.
- Sits between the calculator result register and the board's segment/anode pins.

---
 rtl/seg7_scan_driver.sv | 141 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit hex seven-segment driver: shadow register, refresh prescaler, digit scan, blanking.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_driver #(
   parameter int DIGITS         = 4,
   parameter int REFRESH_DIV    = 50000,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic                  JM1222HM_clk,
   input  logic                  JM1222HM_rst,
   input  logic [4*DIGITS-1:0]   JM1222HM_value,
   input  logic                  JM1222HM_load,
   input  logic [DIGITS-1:0]     JM1222HM_blank,
   output logic [6:0]            JM1222HM_seg,
   output logic [DIGITS-1:0]     JM1222HM_an,
   output logic                  JM1222HM_scan_tick
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int PRE_W = $clog2(REFRESH_DIV);

   localparam logic [6:0]        SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [DIGITS-1:0] AN_OFF   = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
   localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);

   logic [4*DIGITS-1:0] shadow;
   logic [PRE_W-1:0]    prescale;
   logic [IDX_W-1:0]    idx;
   logic [DIGITS-1:0]   blank_eff;
   logic [3:0]          cur_nib;
   logic                cur_blank;
   logic [DIGITS-1:0]   an_hot;
   logic [6:0]          seg_lit;

   // Active-high segment pattern, bit 6 = a ... bit 0 = g.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0:    s = 7'b1111110;
         4'h1:    s = 7'b0110000;
         4'h2:    s = 7'b1101101;
         4'h3:    s = 7'b1111001;
         4'h4:    s = 7'b0110011;
         4'h5:    s = 7'b1011011;
         4'h6:    s = 7'b1011111;
         4'h7:    s = 7'b1110000;
         4'h8:    s = 7'b1111111;
         4'h9:    s = 7'b1111011;
         4'hA:    s = 7'b1110111;
         4'hB:    s = 7'b0011111;
         4'hC:    s = 7'b1001110;
         4'hD:    s = 7'b0111101;
         4'hE:    s = 7'b1001111;
         default: s = 7'b1000111;
      endcase
      return s;
   endfunction

`ifdef SEG7_LZB_EN
   logic [DIGITS-1:0] lz_mask;

   // Digit i>0 is a leading zero when it and every digit above it are zero.
   function automatic logic [DIGITS-1:0] lz_calc(input logic [4*DIGITS-1:0] v);
      logic [DIGITS-1:0] m;
      logic              zero_above;
      m          = '0;
      zero_above = 1'b1;
      for (int i = DIGITS - 1; i > 0; i--) begin
         zero_above = zero_above & (v[4*i +: 4] == 4'h0);
         m[i]       = zero_above;
      end
      return m;
   endfunction

   // Mask tracks the shadow register, so it is captured on the same load edge.
   always_ff @(posedge JM1222HM_clk) begin
      if (JM1222HM_rst) begin
         lz_mask <= lz_calc('0);
      end else if (JM1222HM_load) begin
         lz_mask <= lz_calc(JM1222HM_value);
      end
   end

   assign blank_eff = JM1222HM_blank | lz_mask;
`else
   assign blank_eff = JM1222HM_blank;
`endif

   always_comb begin
      cur_nib   = 4'h0;
      cur_blank = 1'b0;
      an_hot    = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            cur_nib   = shadow[4*i +: 4];
            cur_blank = blank_eff[i];
            an_hot[i] = 1'b1;
         end
      end
      seg_lit = hex_to_seg(cur_nib);
   end

   always_ff @(posedge JM1222HM_clk) begin
      if (JM1222HM_rst) begin
         shadow <= '0;
      end else if (JM1222HM_load) begin
         shadow <= JM1222HM_value;
      end
   end

   // Refresh prescaler and digit index; scan_tick marks the cycle the new index is live.
   always_ff @(posedge JM1222HM_clk) begin
      if (JM1222HM_rst) begin
         prescale           <= '0;
         idx                <= '0;
         JM1222HM_scan_tick <= 1'b0;
      end else if (prescale == PRE_LAST) begin
         prescale           <= '0;
         idx                <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         JM1222HM_scan_tick <= 1'b1;
      end else begin
         prescale           <= prescale + 1'b1;
         JM1222HM_scan_tick <= 1'b0;
      end
   end

   always_ff @(posedge JM1222HM_clk) begin
      if (JM1222HM_rst) begin
         JM1222HM_seg <= SEG_OFF;
         JM1222HM_an  <= AN_OFF;
      end else if (cur_blank) begin
         JM1222HM_seg <= SEG_OFF;
         JM1222HM_an  <= AN_OFF;
      end else begin
         JM1222HM_seg <= SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
         JM1222HM_an  <= AN_ACTIVE_LOW ? ~an_hot : an_hot;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed steps then random loads/blanks/resets against a cycle-count model.
module tb_seg7_scan_driver;

   localparam int D  = 4;
   localparam int RD = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [15:0]   value;
   logic          load;
   logic [3:0]    blank;
   logic [6:0]    seg;
   logic [3:0]    an;
   logic          tick;

   int checks   = 0;
   int failures = 0;

   // Model state: edges since last reset and the loaded value.
   int          n       = 0;
   logic [15:0] shadow_m = '0;
   bit          known   = 1'b0;

   string tbl[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                      "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

   seg7_scan_driver #(
      .DIGITS(D), .REFRESH_DIV(RD), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
   ) dut (
      .JM1222HM_clk(clk),
      .JM1222HM_rst(rst),
      .JM1222HM_value(value),
      .JM1222HM_load(load),
      .JM1222HM_blank(blank),
      .JM1222HM_seg(seg),
      .JM1222HM_an(an),
      .JM1222HM_scan_tick(tick)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] lit_of(input logic [3:0] v);
      logic [6:0] r;
      string      s;
      int         k;
      r = '0;
      s = tbl[v];
      for (int j = 0; j < s.len(); j++) begin
         k = int'(s[j]) - 97;
         r[6-k] = 1'b1;
      end
      return r;
   endfunction

   function automatic bit lz_blank(input int i);
`ifdef SEG7_LZB_EN
      return (i > 0) && ((shadow_m >> (4*i)) == 16'h0);
`else
      return (i < 0);
`endif
   endfunction

   task automatic step();
      logic [6:0] e_seg;
      logic [3:0] e_an;
      logic       e_tick;
      int         i;
      bit         do_check;
      if (rst) begin
         e_seg  = 7'h7F;
         e_an   = 4'hF;
         e_tick = 1'b0;
      end else begin
         i      = (n / RD) % D;
         e_tick = ((n + 1) % RD) == 0;
         if (blank[i] || lz_blank(i)) begin
            e_seg = 7'h7F;
            e_an  = 4'hF;
         end else begin
            e_seg = ~lit_of(shadow_m[4*i +: 4]);
            e_an  = ~(4'b0001 << i);
         end
      end
      do_check = known || rst;
      if (rst) begin
         n        = 0;
         shadow_m = '0;
         known    = 1'b1;
      end else begin
         n = n + 1;
         if (load) shadow_m = value;
      end
      @(posedge clk);
      @(negedge clk);
      if (do_check) begin
         checks++;
         assert (seg === e_seg) else begin
            failures++;
            $error("FAIL seg n=%0d got=%h exp=%h", n, seg, e_seg);
         end
         checks++;
         assert (an === e_an) else begin
            failures++;
            $error("FAIL an n=%0d got=%h exp=%h", n, an, e_an);
         end
         checks++;
         assert (tick === e_tick) else begin
            failures++;
            $error("FAIL scan_tick n=%0d got=%b exp=%b", n, tick, e_tick);
         end
      end
   endtask

   initial begin
      rst   = 1'b1;
      load  = 1'b0;
      value = '0;
      blank = '0;
      @(negedge clk);
      repeat (3) step();
      rst = 1'b0;

      value = 16'h1234; load = 1'b1;
      step();
      load = 1'b0;
      repeat (16) step();

      value = 16'hFFFF;
      repeat (8) step();

      load = 1'b1; rst = 1'b1;
      step();
      load = 1'b0; rst = 1'b0;
      repeat (4) step();

      value = 16'h8888; load = 1'b1;
      step();
      load = 1'b0; blank = 4'b0100;
      repeat (16) step();
      blank = '0;

      // Reset when index=2 and prescaler=3.
      while ((n % (D*RD)) != 2*RD + RD - 1) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (12) step();

      value = 16'h0070; load = 1'b1;
      step();
      load = 1'b0;
      repeat (16) step();
      value = 16'h0000; load = 1'b1;
      step();
      load = 1'b0;
      repeat (16) step();

      repeat (600) begin
         value = 16'($urandom);
         if ($urandom_range(0, 3) == 0) value = value & 16'h00FF;
         load  = ($urandom_range(0, 7) == 0);
         blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
         rst   = ($urandom_range(0, 60) == 0);
         step();
      end
      rst = 1'b0; load = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
